// File: rtl/tinytpu_pkg.sv
// Shared definitions for the tiny TPU sequencing logic.
//   seq_state_t : 3-bit sequencer state encoding
//   DRAIN_CYC   : cycles needed for the last operands to ripple through
//                 an NxN output-stationary array (2*(N-1))
package tinytpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_DRAIN = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } seq_state_t;

   function automatic int DRAIN_CYC(input int n);
      return 2 * (n - 1);
   endfunction

endpackage

// File: rtl/systolic_row_streamer.sv
// Result row streamer: walks out_row 0..N-1 over a valid/ready handshake.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   go         : 1-cycle pulse, start streaming from row 0 next cycle
//   abort      : cancel streaming; masks out_valid in the same cycle
//   out_ready  : consumer accepts the current row
//   out_valid  : a result row is being presented
//   out_row    : row select for the result mux
//   out_last   : out_valid on the final row
//   fin        : final row transferred this cycle
module systolic_row_streamer #(
   parameter int ARRAY_SIZE = 4,
   parameter int RW         = $clog2(ARRAY_SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   input  logic          abort,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [RW-1:0] out_row,
   output logic          out_last,
   output logic          fin
);

   localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_SIZE - 1);

   logic          active_reg;
   logic [RW-1:0] row_reg;
   logic          xfer;
   logic          on_last;

   // Abort must kill the handshake in the very cycle it is raised, so the
   // valid is gated by the raw abort input rather than waiting a cycle.
   assign out_valid = active_reg & ~abort;
   assign xfer      = out_valid & out_ready;
   assign on_last   = (row_reg == LAST_ROW);
   assign out_last  = out_valid & on_last;
   assign fin       = xfer & on_last;
   assign out_row   = row_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         active_reg <= 1'b0;
         row_reg    <= '0;
      end else if (abort || fin) begin
         active_reg <= 1'b0;
         row_reg    <= '0;
      end else if (go) begin
         active_reg <= 1'b1;
         row_reg    <= '0;
      end else if (xfer) begin
         row_reg    <= row_reg + RW'(1);
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic array.
// Runs one tile: optional accumulator clear, k_len feed cycles, 2*(N-1)
// drain cycles, then streams N result rows out over valid/ready.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a tile (only honoured in IDLE)
//   k_len         : feed cycles for the tile, legal range 1..K_MAX
//   accumulate    : 1 keeps PE sums from the previous tile (no CLEAR)
//   abort         : cancel the tile in flight
//   busy          : tile in progress (CLEAR/LOAD/DRAIN/READ)
//   done          : 1-cycle completion pulse
//   err           : 1-cycle pulse after a start with illegal k_len
//   pe_en         : PE enable during LOAD and DRAIN
//   pe_clear_acc  : clear PE accumulators (CLEAR)
//   skew_load_en  : skew buffers accept operands (LOAD)
//   skew_flush    : flush skew registers (CLEAR, or the abort cycle)
//   cycle_count   : feed index through LOAD, continuing through DRAIN
//   out_valid/out_ready/out_row/out_last : result row stream
module systolic_seq_ctrl
   import tinytpu_pkg::*;
#(
   parameter int ARRAY_SIZE = 4,
   parameter int K_MAX      = 16,
   parameter int KW         = $clog2(K_MAX + 1),
   parameter int CW         = $clog2(K_MAX + 2 * ARRAY_SIZE),
   parameter int RW         = $clog2(ARRAY_SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic          accumulate,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          pe_en,
   output logic          pe_clear_acc,
   output logic          skew_load_en,
   output logic          skew_flush,
   output logic [CW-1:0] cycle_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_row,
   output logic          out_last
);

   localparam logic [CW-1:0] DRAIN_LEN = CW'(DRAIN_CYC(ARRAY_SIZE));

   seq_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [KW-1:0] klen_reg, klen_next;
   logic          err_reg, err_next;

   logic          go;
   logic          fin;
   logic          start_ok;
   logic          legal;
   logic [CW-1:0] load_end;
   logic [CW-1:0] drain_end;
   logic          in_feed;
   logic          was_feed;

   assign legal    = (k_len != '0) && (k_len <= KW'(K_MAX));
   // abort has priority over a simultaneous start in IDLE
   assign start_ok = (state_reg == S_IDLE) && start && !abort;

   // The counter runs 0..k_len-1 in LOAD and keeps counting through DRAIN,
   // so both phase ends are expressed against the latched k_len.
   assign load_end  = CW'(klen_reg) - CW'(1);
   assign drain_end = CW'(klen_reg) + DRAIN_LEN - CW'(1);

   always_comb begin
      state_next = state_reg;
      go         = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start_ok && legal)
               state_next = accumulate ? S_LOAD : S_CLEAR;
         end
         S_CLEAR: begin
            state_next = abort ? S_IDLE : S_LOAD;
         end
         S_LOAD: begin
            if (abort)
               state_next = S_IDLE;
            else if (cnt_reg == load_end)
               state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (cnt_reg == drain_end) begin
               state_next = S_READ;
               go         = 1'b1;
            end
         end
         S_READ: begin
            if (abort)
               state_next = S_IDLE;
            else if (fin)
               state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign in_feed  = (state_next == S_LOAD) || (state_next == S_DRAIN);
   assign was_feed = (state_reg == S_LOAD) || (state_reg == S_DRAIN);

   always_comb begin
      cnt_next = '0;
      if (in_feed)
         cnt_next = was_feed ? (cnt_reg + CW'(1)) : '0;
   end

   assign klen_next = (start_ok && legal) ? k_len : klen_reg;
   assign err_next  = start_ok && !legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         klen_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         klen_reg  <= klen_next;
         err_reg   <= err_next;
      end
   end

   systolic_row_streamer #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .RW         (RW)
   ) u_streamer (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .abort     (abort),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_row   (out_row),
      .out_last  (out_last),
      .fin       (fin)
   );

   // Outputs decode the state register; the only input-dependent terms are
   // the abort masks, which must act in the abort cycle itself.
   assign busy         = (state_reg == S_CLEAR) || (state_reg == S_LOAD) ||
                         (state_reg == S_DRAIN) || (state_reg == S_READ);
   assign done         = (state_reg == S_DONE);
   assign err          = err_reg;
   assign pe_en        = ((state_reg == S_LOAD) || (state_reg == S_DRAIN)) && !abort;
   assign pe_clear_acc = (state_reg == S_CLEAR);
   assign skew_load_en = (state_reg == S_LOAD);
   assign skew_flush   = (state_reg == S_CLEAR) || (busy && abort);
   assign cycle_count  = cnt_reg;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (N=4, K_MAX=16).
// The reference model derives the expected phase of every cycle from the
// tile timeline: [CLEAR] LOAD x k_len, DRAIN x 2(N-1), READ until N rows
// have been accepted, then DONE.
module tb_systolic_seq_ctrl;

   localparam int N  = 4;
   localparam int KM = 16;
   localparam int KW = 5;
   localparam int CW = 5;
   localparam int RW = 2;
   localparam int D  = 2 * (N - 1);

   typedef enum int {P_CLEAR, P_LOAD, P_DRAIN, P_READ, P_DONE} phase_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          accumulate;
   logic          abort;
   logic          busy;
   logic          done;
   logic          err;
   logic          pe_en;
   logic          pe_clear_acc;
   logic          skew_load_en;
   logic          skew_flush;
   logic [CW-1:0] cycle_count;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_row;
   logic          out_last;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   systolic_seq_ctrl #(
      .ARRAY_SIZE (N),
      .K_MAX      (KM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .k_len        (k_len),
      .accumulate   (accumulate),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .pe_en        (pe_en),
      .pe_clear_acc (pe_clear_acc),
      .skew_load_en (skew_load_en),
      .skew_flush   (skew_flush),
      .cycle_count  (cycle_count),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_last     (out_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_outputs(input string ph, input int i,
                                 input logic eb, input logic ed, input logic ee,
                                 input logic epe, input logic ecl, input logic esl,
                                 input logic esf, input int ecc, input logic eov,
                                 input int erow, input logic elast);
      string p;
      p = $sformatf("%s@%0d", ph, i);
      chk({p, ".busy"},         32'(busy),         32'(eb));
      chk({p, ".done"},         32'(done),         32'(ed));
      chk({p, ".err"},          32'(err),          32'(ee));
      chk({p, ".pe_en"},        32'(pe_en),        32'(epe));
      chk({p, ".pe_clear_acc"}, 32'(pe_clear_acc), 32'(ecl));
      chk({p, ".skew_load_en"}, 32'(skew_load_en), 32'(esl));
      chk({p, ".skew_flush"},   32'(skew_flush),   32'(esf));
      chk({p, ".cycle_count"},  32'(cycle_count),  ecc);
      chk({p, ".out_valid"},    32'(out_valid),    32'(eov));
      chk({p, ".out_row"},      32'(out_row),      erow);
      chk({p, ".out_last"},     32'(out_last),     32'(elast));
   endtask

   task automatic idle_check(input string ph, input int i, input logic ee);
      expect_outputs(ph, i, 0, 0, ee, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One tile from the start request onward. kill_cycle (>0) raises abort,
   // or rst when kill_rst is set, in that cycle of the tile. noise keeps
   // start asserted with random k_len while the tile is in flight.
   task automatic run_tile(input int k, input bit acc, input int ready_pct,
                           input int stall_row, input int kill_cycle,
                           input bit kill_rst, input bit noise, output int done_at);
      int     c;
      int     xfers;
      int     stalls;
      int     ecc;
      bit     ab;
      bit     eb;
      phase_t ph;
      done_at = 0;
      @(negedge clk);
      start = 1'b1; k_len = KW'(k); accumulate = acc; abort = 1'b0; rst = 1'b0; out_ready = 1'b1;
      #1;
      idle_check("start", 0, 0);
      c      = acc ? 0 : 1;
      xfers  = 0;
      stalls = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (i <= c)              ph = P_CLEAR;
         else if (i <= c + k)     ph = P_LOAD;
         else if (i <= c + k + D) ph = P_DRAIN;
         else if (xfers < N)      ph = P_READ;
         else                     ph = P_DONE;
         start      = noise | ($urandom_range(3) == 0);
         k_len      = KW'($urandom_range(31));
         accumulate = 1'($urandom_range(1));
         ab         = (i == kill_cycle) && !kill_rst;
         if (ph == P_DONE) ab = 1'($urandom_range(1));
         abort = ab;
         rst   = (i == kill_cycle) && kill_rst;
         if (ph == P_READ) begin
            if (stall_row == xfers && stalls < 3) begin
               out_ready = 1'b0;
               stalls++;
            end else begin
               out_ready = ($urandom_range(99) < ready_pct);
            end
         end else begin
            out_ready = 1'($urandom_range(1));
         end
         #1;
         eb  = (ph != P_DONE);
         ecc = (ph == P_LOAD || ph == P_DRAIN) ? (i - 1 - c) : 0;
         expect_outputs(ph.name(), i, eb, ph == P_DONE, 0,
                        (ph == P_LOAD || ph == P_DRAIN) && !ab,
                        ph == P_CLEAR, ph == P_LOAD, (ph == P_CLEAR) || (eb && ab),
                        ecc, (ph == P_READ) && !ab, (ph == P_READ) ? xfers : 0,
                        (ph == P_READ) && !ab && (xfers == N - 1));
         if (done === 1'b1) done_at = i;
         if (i == kill_cycle) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            #1;
            idle_check("killed", i + 1, 0);
            $display("tile k=%0d acc=%0d killed(%s) at cycle %0d, done_at=%0d",
                     k, acc, kill_rst ? "rst" : "abort", i, done_at);
            return;
         end
         if (ph == P_DONE) begin
            $display("tile k=%0d acc=%0d ready=%0d%% done at cycle %0d", k, acc, ready_pct, done_at);
            return;
         end
         if (ph == P_READ && out_ready && !ab) xfers++;
      end
      chk("tile_timeout", 32'(xfers), 32'(-1));
   endtask

   task automatic try_illegal(input int k);
      @(negedge clk);
      start = 1'b1; k_len = KW'(k); abort = 1'b0; accumulate = 1'b0;
      #1;
      idle_check("ill_req", 0, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      idle_check("ill_err", 1, 1);
      @(negedge clk);
      #1;
      idle_check("ill_after", 2, 0);
      $display("illegal start k=%0d checked", k);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int da;
      int k;
      int kill;
      bit acc;
      rst = 1'b1; start = 1'b0; k_len = '0; accumulate = 1'b0; abort = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      idle_check("reset", 0, 0);
      rst = 1'b0;

      run_tile(4, 0, 100, -1, -1, 0, 0, da);
      chk("latency_acc0", da, 16);
      run_tile(4, 1, 100, -1, -1, 0, 0, da);
      chk("latency_acc1", da, 15);
      run_tile(4, 0, 100, 2, -1, 0, 0, da);
      chk("latency_stall_row2", da, 19);
      run_tile(4, 0, 100, -1, 3, 0, 0, da);
      chk("abort_no_done", da, 0);
      run_tile(2, 0, 100, -1, -1, 0, 0, da);
      chk("latency_after_abort", da, 14);

      try_illegal(0);
      try_illegal(17);

      // abort together with start in IDLE: start dropped, no err
      @(negedge clk);
      start = 1'b1; abort = 1'b1; k_len = KW'(5);
      #1;
      idle_check("ab_start", 0, 0);
      @(negedge clk);
      k_len = KW'(0);
      #1;
      idle_check("ab_start_next", 1, 0);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      idle_check("ab_illegal_next", 2, 0);
      $display("abort+start in IDLE checked");

      // start held through the tile, rst on the second READ row
      run_tile(3, 0, 100, -1, 12, 1, 1, da);
      chk("rst_no_done", da, 0);
      @(negedge clk);
      #1;
      idle_check("post_rst", 1, 0);

      for (int t = 0; t < 25; t++) begin
         k    = int'($urandom_range(KM, 1));
         acc  = 1'($urandom_range(1));
         kill = ($urandom_range(3) == 0) ? int'($urandom_range(k + D + 2, 1)) : -1;
         run_tile(k, acc, int'($urandom_range(100, 30)), -1, kill,
                  1'($urandom_range(1)), 1'($urandom_range(1)), da);
         if (kill < 0) chk("rand_done_seen", 32'(da > 0), 32'(1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
